// File: rtl/gray_conv_scheduler_pkg.sv
// gray_pkg: shared types and widths for the Gray conversion scheduler.
//   state_e  : scheduler FSM states (IDLE, HIGH, LOW, HOLD)
//   NIBBLE_W : width of the shared conversion unit
//   WORD_W   : width of a full binary / Gray word
//   req_id_t : requester index (two requesters)
package gray_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        HOLD = 2'd3
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/gray_conv_scheduler_nibble.sv
// gray_nibble_unit: purely combinational 4-bit binary-to-Gray slice.
//   bin  [3:0] : binary nibble
//   nbr        : next-more-significant binary bit (0 for the top nibble)
//   gray [3:0] : Gray nibble, gray[3] = bin[3]^nbr, gray[i] = bin[i]^bin[i+1]
// Chaining the neighbour bit across nibbles yields a true word-wide Gray code.
module gray_nibble_unit
    import gray_pkg::*;
(
    input  logic [NIBBLE_W-1:0] bin,
    input  logic                nbr,
    output logic [NIBBLE_W-1:0] gray
);

    assign gray[NIBBLE_W-1] = bin[NIBBLE_W-1] ^ nbr;

    generate
        for (genvar gi = 0; gi < NIBBLE_W - 1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_conv_scheduler.sv
// gray_conv_scheduler: shares one gray_nibble_unit between two requesters.
//   clk, rst              : clock, asynchronous active-high reset
//   reqN_valid/data/ready : requester N handshake (ready is combinational)
//   out_valid/data/id     : registered result, Gray word and owning requester
//   out_ready             : consumer accepts the result held in HOLD
// Parameter RR_EN: 1 = round-robin on contention, 0 = req0 has fixed priority.
// A word is accepted in IDLE, converted high nibble (HIGH) then low nibble
// (LOW), and presented in HOLD until out_ready.
module gray_conv_scheduler
    import gray_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   bin_q, bin_d;
    logic [WORD_W-1:0]   gray_q, gray_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    req_id_t             id_q, id_d;
    req_id_t             rr_last_q, rr_last_d;
    req_id_t             out_id_q, out_id_d;
    logic                out_valid_q, out_valid_d;

    req_id_t             grant;
    logic                any_valid;
    logic                accept;
    logic [NIBBLE_W-1:0] nib_bin;
    logic                nib_nbr;
    logic [NIBBLE_W-1:0] nib_gray;

    // Arbiter: on contention round-robin favours whoever was not served last.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? req_id_t'(~rr_last_q) : req_id_t'(1'b0);
        end else begin
            grant = req_id_t'(req1_valid);
        end
    end

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign req0_ready = !rst && (state_q == IDLE) && any_valid && (grant == 1'b0);
    assign req1_ready = !rst && (state_q == IDLE) && any_valid && (grant == 1'b1);
    assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    // Single shared nibble unit: high nibble first (no neighbour above it),
    // then low nibble with bin_q[4] carried down as its neighbour.
    always_comb begin
        if (state_q == LOW) begin
            nib_bin = bin_q[NIBBLE_W-1:0];
            nib_nbr = bin_q[NIBBLE_W];
        end else begin
            nib_bin = bin_q[WORD_W-1:NIBBLE_W];
            nib_nbr = 1'b0;
        end
    end

    gray_nibble_unit u_nibble (
        .bin  (nib_bin),
        .nbr  (nib_nbr),
        .gray (nib_gray)
    );

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        gray_d      = gray_q;
        id_d        = id_q;
        rr_last_d   = rr_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bin_d     = (grant == 1'b1) ? req1_data : req0_data;
                    id_d      = grant;
                    rr_last_d = grant;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                gray_d[WORD_W-1:NIBBLE_W] = nib_gray;
                state_d                   = LOW;
            end
            LOW: begin
                gray_d[NIBBLE_W-1:0] = nib_gray;
                // Output registers load the complete word on HOLD entry so
                // out_data is valid in the same cycle out_valid rises.
                out_data_d  = {gray_q[WORD_W-1:NIBBLE_W], nib_gray};
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            gray_q      <= '0;
            id_q        <= 1'b0;
            rr_last_q   <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            id_q        <= id_d;
            rr_last_q   <= rr_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
